// File: rtl/ha_using_2x1mux.sv
// Registered WIDTH-lane half adder built only from per-lane 2:1 mux cells.
// Optional saturating carry-event counter enabled by the HA_CARRY_CNT_EN macro.
module ha_using_2x1mux #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  output logic [WIDTH-1:0] cy,
  output logic [WIDTH-1:0] s,
`ifdef HA_CARRY_CNT_EN
  output logic [CNT_W-1:0] carry_cnt,
`endif
  output logic             out_valid
);

  logic [WIDTH-1:0] sum_mux;
  logic [WIDTH-1:0] carry_mux;

  // Each lane is two independent 2:1 mux cells; no logic is shared between lanes.
  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    logic b_n;
    assign b_n          = ~b[i];
    assign sum_mux[i]   = a[i] ? b_n  : b[i];
    assign carry_mux[i] = a[i] ? b[i] : 1'b0;
  end

  // Reset asserts asynchronously but releases through two flops, so capture starts on a clean edge.
  logic [1:0] rst_sync_q;
  logic       run;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign run = rst_sync_q[1];

  logic             capture;
  logic [WIDTH-1:0] cy_d, cy_q;
  logic [WIDTH-1:0] s_d, s_q;
  logic             valid_d, valid_q;

  assign capture = run & in_valid;

  always_comb begin
    cy_d    = cy_q;
    s_d     = s_q;
    valid_d = 1'b0;
    if (capture) begin
      cy_d    = carry_mux;
      s_d     = sum_mux;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cy_q    <= '0;
      s_q     <= '0;
      valid_q <= 1'b0;
    end else begin
      cy_q    <= cy_d;
      s_q     <= s_d;
      valid_q <= valid_d;
    end
  end

  assign cy        = cy_q;
  assign s         = s_q;
  assign out_valid = valid_q;

`ifdef HA_CARRY_CNT_EN
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             carry_event;

  assign carry_event = capture & (|carry_mux);

  always_comb begin
    cnt_d = cnt_q;
    if (carry_event && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign carry_cnt = cnt_q;
`else
  logic unused_cnt_w;
  assign unused_cnt_w = ^CNT_W;
`endif

endmodule

// File: tb/tb_ha_using_2x1mux.sv
// Scoreboard bench for ha_using_2x1mux: directed vectors queue expected {cy,s}, a monitor compares.
module tb_ha_using_2x1mux;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned CNT_W = 2;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             in_valid;
  logic [WIDTH-1:0] cy;
  logic [WIDTH-1:0] s;
  logic             out_valid;
`ifdef HA_CARRY_CNT_EN
  logic [CNT_W-1:0] carry_cnt;
`endif

  ha_using_2x1mux #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .a        (a),
    .b        (b),
    .in_valid (in_valid),
    .cy       (cy),
    .s        (s),
`ifdef HA_CARRY_CNT_EN
    .carry_cnt(carry_cnt),
`endif
    .out_valid(out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic [2*WIDTH-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: every presented result must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_output: got cy=%b s=%b, expected no output", cy, s);
      end else begin
        logic [2*WIDTH-1:0] e;
        e = exp_q.pop_front();
        check("cy_s", {24'd0, cy, s}, {24'd0, e});
      end
    end
  end

  // Drive one qualified pair with its hand-computed result.
  task automatic send(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb,
                      input logic [WIDTH-1:0] ecy, input logic [WIDTH-1:0] es);
    @(posedge clk);
    #2;
    a        = va;
    b        = vb;
    in_valid = 1'b1;
    exp_q.push_back({ecy, es});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #2;
      in_valid = 1'b0;
    end
  endtask

  task automatic check_cleared(input string name);
    check({name, "_cy"}, {28'd0, cy}, 32'd0);
    check({name, "_s"}, {28'd0, s}, 32'd0);
    check({name, "_valid"}, {31'd0, out_valid}, 32'd0);
`ifdef HA_CARRY_CNT_EN
    check({name, "_cnt"}, {30'd0, carry_cnt}, 32'd0);
`endif
  endtask

  typedef struct packed {
    logic [WIDTH-1:0] va;
    logic [WIDTH-1:0] vb;
    logic [WIDTH-1:0] ecy;
    logic [WIDTH-1:0] es;
  } vec_t;

  vec_t mixed[8];

  initial begin
    mixed[0] = '{4'b1011, 4'b0110, 4'b0010, 4'b1101};
    mixed[1] = '{4'b0101, 4'b0101, 4'b0101, 4'b0000};
    mixed[2] = '{4'b1111, 4'b0000, 4'b0000, 4'b1111};
    mixed[3] = '{4'b1001, 4'b1111, 4'b1001, 4'b0110};
    mixed[4] = '{4'b0011, 4'b1100, 4'b0000, 4'b1111};
    mixed[5] = '{4'b1110, 4'b0111, 4'b0110, 4'b1001};
    mixed[6] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000};
    mixed[7] = '{4'b1111, 4'b1111, 4'b1111, 4'b0000};

    // Reset held while clocking with a=b=1 and in_valid=1.
    rst_n    = 1'b0;
    a        = '1;
    b        = '1;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check_cleared("reset_hold");
    end
    #1;
    rst_n    = 1'b1;
    in_valid = 1'b0;
    idle(4);

    // Truth table on lane 0.
    send(4'b0000, 4'b0000, 4'b0000, 4'b0000);
    send(4'b0000, 4'b0001, 4'b0000, 4'b0001);
    send(4'b0001, 4'b0000, 4'b0000, 4'b0001);
    send(4'b0001, 4'b0001, 4'b0001, 4'b0000);
    // Multi-lane independence.
    send(4'b1100, 4'b1010, 4'b1000, 4'b0110);
    for (int i = 0; i < 8; i++) send(mixed[i].va, mixed[i].vb, mixed[i].ecy, mixed[i].es);
    idle(2);

    // Hold: result stays while in_valid is low, out_valid drops.
    send(4'b0001, 4'b0000, 4'b0000, 4'b0001);
    @(posedge clk);
    #2;
    a        = '1;
    b        = '1;
    in_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      check("hold_s", {28'd0, s}, 32'h1);
      check("hold_cy", {28'd0, cy}, 32'h0);
      check("hold_valid", {31'd0, out_valid}, 32'h0);
    end

    // Mid-stream reset clears outputs at once; the pending result is discarded.
    send(4'b1111, 4'b0000, 4'b0000, 4'b1111);
    @(posedge clk);
    #1;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    exp_q.delete();
    #1;
    check_cleared("mid_reset");
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    idle(4);
    send(4'b0110, 4'b0011, 4'b0010, 4'b0101);
    idle(2);

`ifdef HA_CARRY_CNT_EN
    rst_n = 1'b0;
    #1;
    check("cnt_reset", {30'd0, carry_cnt}, 32'd0);
    rst_n = 1'b1;
    idle(4);
    send(4'b0001, 4'b0001, 4'b0001, 4'b0000);
    send(4'b0001, 4'b0001, 4'b0001, 4'b0000);
    idle(1);
    check("cnt_two", {30'd0, carry_cnt}, 32'd2);
    send(4'b0001, 4'b0010, 4'b0000, 4'b0011);
    idle(1);
    check("cnt_no_carry", {30'd0, carry_cnt}, 32'd2);
    for (int i = 0; i < 3; i++) send(4'b0001, 4'b0001, 4'b0001, 4'b0000);
    idle(1);
    check("cnt_sat", {30'd0, carry_cnt}, 32'd3);
    rst_n = 1'b0;
    #1;
    check("cnt_clear", {30'd0, carry_cnt}, 32'd0);
    rst_n = 1'b1;
    idle(4);
`endif

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
    #6;
    check("queue_drained", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
